phase_accumulator: RTL and testbench
====================================

// Module: phase_accumulator
// PURPOSE
//  DDS phase accumulator: the stage directly upstream of the phase-to-amplitude converter.
//  Integrates a frequency tuning word (FTW) every enabled clock into an M-bit accumulator.
//  Outputs the truncated N-bit phase plus a phase offset (POW), registered, to drive pac.phase.
//  FTW/POW are double-buffered; updates apply immediately or phase-synchronously at the next wrap.
// PARAMETERS
//  M  32  accumulator / FTW width (M >= N)
//  N  14  output phase width; equals pac N
// PORTS
//  clk        in   1    single clock, rising edge
//  rst_n      in   1    asynchronous active-low reset
//  en         in   1    accumulate enable; 0 = hold
//  clr        in   1    synchronous accumulator clear
//  ftw_in     in   M    tuning word data
//  ftw_wr     in   1    1-cycle strobe: ftw_in -> shadow FTW
//  pow_in     in   N    phase offset data
//  pow_wr     in   1    1-cycle strobe: pow_in -> shadow POW
//  update     in   1    1-cycle strobe: shadow -> active
//  sync_mode  in   1    0 = apply at next edge; 1 = apply at next wrap
//  phase      out  N    registered (acc[M-1:M-N] + pow_act) mod 2^N
//  wrap       out  1    1-cycle pulse, aligned with phase, on accumulator carry-out
//  pending    out  1    high while a sync-mode update waits for a wrap
// BEHAVIOUR
//  - Reset (async, rst_n=0): acc, shadow/active FTW, shadow/active POW, phase, wrap, pending = 0; FSM = IDLE.
//  - Accumulate: when en=1, acc <= (acc + ftw_act) mod 2^M, carry = overflow of the M-bit add.
//    When en=0, acc holds; wrap = 0.
//  - Output: phase <= acc_next[M-1:M-N] + pow_act (N-bit wrap-around).
//    wrap <= carry & en. Latency: FTW edge-in to phase = 1 clk after active load.
//  - clr=1: acc <= 0, phase <= pow_act, wrap <= 0. clr takes priority over en.
//    Shadow, active and pending are untouched.
//  - Shadow writes: ftw_wr/pow_wr load their shadow registers every cycle, independent of en.
//  - Update FSM, two states:
//    IDLE: update & !sync_mode -> active <= shadow this edge, stay IDLE.
//          update & sync_mode -> PENDING, pending=1.
//    PENDING: on the cycle whose add carries (en=1) -> active <= shadow, IDLE, pending=0;
//             new FTW is used from the following add.
//             A second update while PENDING is absorbed; it does not restart.
//             update & !sync_mode while PENDING -> immediate load, IDLE.
//  - Simultaneous ftw_wr/pow_wr and update (either mode): the value written this cycle is the one
//    transferred (write bypasses into the active load path).
//  - Shadow write while PENDING: the latest shadow value at wrap time is loaded.
//  - en=0 while PENDING: waits indefinitely. clr while PENDING: stays PENDING (no carry generated).
//  - FTW=0: phase constant, no wrap. FTW >= 2^(M-1): wrap nearly every cycle; behaviour unchanged.
//  - Reset mid-operation: immediate return to reset values; pending update discarded.
// STRUCTURE
//  - dds_defs.vh (shared header): default M/N, FSM state encodings IDLE=1'b0, PENDING=1'b1.
//    Used by pac and the top level.
//  - One sub-module, phase_update_ctrl: shadow + active FTW/POW registers, bypass mux,
//    IDLE/PENDING FSM, pending output.
//  - Top holds the adder, carry, clr/en mux, and output phase/wrap registers.
// TESTING (M=32, N=14)
//  1. Reset, ftw_in=2^30, ftw_wr+update (sync_mode=0), en=1 ->
//     phase 0,4096,8192,12288,0; wrap=1 on the 0 after 12288, period 4.
//  2. Running FTW=2^30; write 2^29 with update, sync_mode=1 mid-cycle ->
//     pending=1 until wrap, then steps of 2048; no step of 2048 before the wrap.
//  3. pow_in=8192, pow_wr+update (immediate), FTW=0 -> phase=8192 constant, wrap never asserts.
//  4. FTW=2^30, en low 3 cycles at phase=4096 -> phase holds 4096, wrap=0; resumes 8192 on en=1.
//  5. clr asserted at phase=12288 with POW=100 -> next phase=100, wrap=0, active FTW unchanged.
//  6. rst_n low asynchronously (mid-clock) while PENDING -> phase, wrap, pending=0 immediately;
//     after release, FTW=0 until a new update.

Source files
------------

// File: rtl/phase_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// phase_accumulator_pkg
//   Shared definitions for the DDS phase accumulator slice.
//   - Default accumulator width (M) and output phase width (N).
//   - Encoding of the tuning-word update controller states.
// ---------------------------------------------------------------------------
package phase_accumulator_pkg;

  // Default accumulator / FTW width
  localparam int unsigned M_DEF = 32;
  // Default output phase width; must match the downstream converter
  localparam int unsigned N_DEF = 14;

  // Update controller states: IDLE = no update waiting, PENDING = waiting for a wrap
  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } upd_state_e;

endpackage : phase_accumulator_pkg

// File: rtl/phase_accumulator_update_ctrl.sv
// ---------------------------------------------------------------------------
// phase_update_ctrl
//   Double-buffered FTW / POW registers with the immediate / phase-synchronous
//   update state machine.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     ftw_in, ftw_wr    tuning word data and shadow write strobe
//     pow_in, pow_wr    phase offset data and shadow write strobe
//     update            shadow -> active transfer request
//     sync_mode         0 = transfer at this edge, 1 = transfer at the next wrap
//     carry             accumulator carry-out of the current enabled add
//     ftw_act, pow_act  active tuning word / phase offset (registered)
//     pending           high while a synchronous update waits for a wrap
// ---------------------------------------------------------------------------
module phase_update_ctrl
  import phase_accumulator_pkg::*;
#(
  parameter int unsigned M = M_DEF,
  parameter int unsigned N = N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [M-1:0] ftw_in,
  input  logic         ftw_wr,
  input  logic [N-1:0] pow_in,
  input  logic         pow_wr,
  input  logic         update,
  input  logic         sync_mode,
  input  logic         carry,
  output logic [M-1:0] ftw_act,
  output logic [N-1:0] pow_act,
  output logic         pending
);

  logic [M-1:0] ftw_shadow_r;
  logic [N-1:0] pow_shadow_r;
  logic [M-1:0] ftw_shadow_nxt_s;
  logic [N-1:0] pow_shadow_nxt_s;
  upd_state_e   state_r;

  // Shadow next-value: a write in the same cycle bypasses straight into the load path
  always_comb begin
    ftw_shadow_nxt_s = ftw_shadow_r;
    pow_shadow_nxt_s = pow_shadow_r;
    if (ftw_wr) begin
      ftw_shadow_nxt_s = ftw_in;
    end else begin
      ftw_shadow_nxt_s = ftw_shadow_r;
    end
    if (pow_wr) begin
      pow_shadow_nxt_s = pow_in;
    end else begin
      pow_shadow_nxt_s = pow_shadow_r;
    end
  end

  // Shadow registers load on their write strobes regardless of accumulate enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ftw_shadow_r <= {M{1'b0}};
      pow_shadow_r <= {N{1'b0}};
    end else begin
      ftw_shadow_r <= ftw_shadow_nxt_s;
      pow_shadow_r <= pow_shadow_nxt_s;
    end
  end

  // Update FSM with registered active words and pending flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ftw_act <= {M{1'b0}};
      pow_act <= {N{1'b0}};
      pending <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (update && !sync_mode) begin
            ftw_act <= ftw_shadow_nxt_s;
            pow_act <= pow_shadow_nxt_s;
          end else if (update && sync_mode) begin
            // A carry in this same cycle does not count; wait for the next one
            state_r <= PENDING;
            pending <= 1'b1;
          end
        end
        PENDING: begin
          // An immediate request overrides the wait; a repeated sync request is absorbed
          if ((update && !sync_mode) || carry) begin
            ftw_act <= ftw_shadow_nxt_s;
            pow_act <= pow_shadow_nxt_s;
            state_r <= IDLE;
            pending <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          pending <= 1'b0;
        end
      endcase
    end
  end

endmodule : phase_update_ctrl

// File: rtl/phase_accumulator.sv
// ---------------------------------------------------------------------------
// phase_accumulator
//   DDS phase accumulator feeding the phase-to-amplitude converter. Adds the
//   active FTW every enabled clock into an M-bit accumulator and outputs the
//   top N bits plus the active phase offset, registered.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     en                accumulate enable (0 = hold)
//     clr               synchronous accumulator clear, overrides en
//     ftw_in, ftw_wr    tuning word data / shadow write strobe
//     pow_in, pow_wr    phase offset data / shadow write strobe
//     update, sync_mode shadow -> active transfer request and its timing mode
//     phase             (acc[M-1:M-N] + pow_act) mod 2^N, registered
//     wrap              one-cycle pulse aligned with phase on accumulator carry
//     pending           synchronous update waiting for a wrap
// ---------------------------------------------------------------------------
module phase_accumulator
  import phase_accumulator_pkg::*;
#(
  parameter int unsigned M = M_DEF,
  parameter int unsigned N = N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [M-1:0] ftw_in,
  input  logic         ftw_wr,
  input  logic [N-1:0] pow_in,
  input  logic         pow_wr,
  input  logic         update,
  input  logic         sync_mode,
  output logic [N-1:0] phase,
  output logic         wrap,
  output logic         pending
);

  logic [M-1:0] acc_r;
  logic [M:0]   sum_s;
  logic [M-1:0] acc_next_s;
  logic         carry_s;
  logic [N-1:0] phase_next_s;
  logic [M-1:0] ftw_act_s;
  logic [N-1:0] pow_act_s;

  phase_update_ctrl #(
    .M (M),
    .N (N)
  ) u_update_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .ftw_in    (ftw_in),
    .ftw_wr    (ftw_wr),
    .pow_in    (pow_in),
    .pow_wr    (pow_wr),
    .update    (update),
    .sync_mode (sync_mode),
    .carry     (carry_s),
    .ftw_act   (ftw_act_s),
    .pow_act   (pow_act_s),
    .pending   (pending)
  );

  // Adder with carry-out; clr beats en and suppresses the carry
  always_comb begin
    sum_s      = {1'b0, acc_r} + {1'b0, ftw_act_s};
    acc_next_s = acc_r;
    carry_s    = 1'b0;
    if (clr) begin
      acc_next_s = {M{1'b0}};
      carry_s    = 1'b0;
    end else if (en) begin
      acc_next_s = sum_s[M-1:0];
      carry_s    = sum_s[M];
    end else begin
      acc_next_s = acc_r;
      carry_s    = 1'b0;
    end
    // Truncate to N bits, then offset; the N-bit add wraps naturally
    phase_next_s = acc_next_s[M-1:M-N] + pow_act_s;
  end

  // Accumulator and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {M{1'b0}};
      phase <= {N{1'b0}};
      wrap  <= 1'b0;
    end else begin
      acc_r <= acc_next_s;
      phase <= phase_next_s;
      wrap  <= carry_s;
    end
  end

endmodule : phase_accumulator

// File: tb/tb_phase_accumulator.sv
// ---------------------------------------------------------------------------
// tb_phase_accumulator
//   Scoreboard bench: the stimulus process steps an arithmetic reference
//   model and queues the expected phase/wrap/pending; a monitor pops and
//   compares one entry after every rising edge.
// ---------------------------------------------------------------------------
module tb_phase_accumulator;

  localparam int unsigned M = 32;
  localparam int unsigned N = 14;
  localparam longint unsigned TWO_M = 64'd4294967296;
  localparam int unsigned TWO_N = 16384;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         clr;
  logic [M-1:0] ftw_in;
  logic         ftw_wr;
  logic [N-1:0] pow_in;
  logic         pow_wr;
  logic         update;
  logic         sync_mode;
  logic [N-1:0] phase;
  logic         wrap;
  logic         pending;

  phase_accumulator #(.M(M), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr       (clr),
    .ftw_in    (ftw_in),
    .ftw_wr    (ftw_wr),
    .pow_in    (pow_in),
    .pow_wr    (pow_wr),
    .update    (update),
    .sync_mode (sync_mode),
    .phase     (phase),
    .wrap      (wrap),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned phase;
    bit          wrap;
    bit          pending;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state (plain arithmetic)
  longint unsigned m_acc, m_ftw_sh, m_ftw_act;
  int unsigned     m_pow_sh, m_pow_act;
  bit              m_pend;

  task automatic model_reset();
    m_acc = 0; m_ftw_sh = 0; m_ftw_act = 0;
    m_pow_sh = 0; m_pow_act = 0; m_pend = 0;
  endtask

  task automatic check(input string name, input longint unsigned act, input longint unsigned req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus: drive at the falling edge, predict the next rising edge
  task automatic cycle(input bit i_en, input bit i_clr, input bit i_ftw_wr, input longint unsigned i_ftw,
                       input bit i_pow_wr, input int unsigned i_pow, input bit i_upd, input bit i_sync);
    longint unsigned total_s, new_acc;
    bit carried, load;
    exp_t e;
    @(negedge clk);
    en = i_en; clr = i_clr; ftw_wr = i_ftw_wr; ftw_in = i_ftw[M-1:0];
    pow_wr = i_pow_wr; pow_in = i_pow[N-1:0]; update = i_upd; sync_mode = i_sync;
    if (i_ftw_wr) m_ftw_sh = i_ftw;
    if (i_pow_wr) m_pow_sh = i_pow;
    total_s = m_acc + m_ftw_act;
    carried = i_en && !i_clr && (total_s >= TWO_M);
    if (i_clr)     new_acc = 0;
    else if (i_en) new_acc = total_s % TWO_M;
    else           new_acc = m_acc;
    e.phase = int'(((new_acc >> (M - N)) + m_pow_act) % TWO_N);
    e.wrap  = carried;
    load = 0;
    if (i_upd && !i_sync)      begin load = 1; m_pend = 0; end
    else if (m_pend && carried) begin load = 1; m_pend = 0; end
    else if (i_upd && i_sync)   m_pend = 1;
    if (load) begin m_ftw_act = m_ftw_sh; m_pow_act = m_pow_sh; end
    m_acc = new_acc;
    e.pending = m_pend;
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare one queued expectation per rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("phase", phase, e.phase);
        check("wrap", wrap, e.wrap);
        check("pending", pending, e.pending);
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; ftw_in = '0; ftw_wr = 1'b0;
    pow_in = '0; pow_wr = 1'b0; update = 1'b0; sync_mode = 1'b0;
    model_reset();
    #12;
    check("reset_phase", phase, 0);
    check("reset_wrap", wrap, 0);
    check("reset_pending", pending, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: FTW = 2^30 immediate -> 0,4096,8192,12288,0(wrap)
    cycle(1, 0, 1, 64'd1073741824, 0, 0, 1, 0);
    run(8);

    // 2: synchronous switch to 2^29 mid-period
    run(1);
    cycle(1, 0, 1, 64'd536870912, 0, 0, 1, 1);
    run(2);
    cycle(1, 0, 0, 0, 0, 0, 1, 1);   // absorbed second request
    run(10);

    // 3: POW=8192 and FTW=0 immediately -> constant 8192, no wrap
    cycle(1, 0, 1, 0, 1, 8192, 1, 0);
    run(6);

    // 4: FTW=2^30, POW=0, then hold for 3 cycles
    cycle(1, 0, 1, 64'd1073741824, 1, 0, 1, 0);
    run(2);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    run(3);

    // 5: POW=100 then clr; FTW unchanged afterwards
    cycle(1, 0, 0, 0, 1, 100, 1, 0);
    run(2);
    cycle(1, 1, 0, 0, 0, 0, 0, 0);
    run(5);
    cycle(1, 1, 0, 0, 0, 0, 1, 1);   // clr while going PENDING: no carry
    run(2);

    // 6: pending with en low, then asynchronous reset mid-clock
    cycle(1, 0, 1, 64'd3000000000, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    en = 1'b0; ftw_wr = 1'b0; pow_wr = 1'b0; update = 1'b0; clr = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_phase", phase, 0);
    check("async_rst_wrap", wrap, 0);
    check("async_rst_pending", pending, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(5);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      longint unsigned f;
      int sel;
      sel = $urandom_range(0, 3);
      case (sel)
        0: f = 0;
        1: f = longint'($urandom_range(0, 65535));
        2: f = 64'd2147483648 + longint'($urandom_range(0, 2147483647));
        default: f = longint'($urandom());
      endcase
      cycle($urandom_range(0, 7) != 0, $urandom_range(0, 31) == 0,
            $urandom_range(0, 3) == 0, f,
            $urandom_range(0, 3) == 0, $urandom_range(0, TWO_N - 1),
            $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
    end
    run(2);
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_phase_accumulator
